len5_runtime_cfg: RTL
=====================

// Module: len5_runtime_cfg
// PURPOSE
// - Runtime-programmable successor of the static core configuration: holds the boot VM mode, boot PC,
//   N memory-mapped (no-forwarding) regions and feature enables as registers, reset to compile-time defaults.
// - Writes land in a shadow copy. The active copy that drives the core updates only after the
//   pipeline is quiescent, through a drain handshake with the commit/control logic.
// - Sits beside the CSR unit. Driven by a simple req/rsp register port. Its outputs feed the LSU
//   (forwarding enable, MMAP check) and the fetch/boot logic.
// PARAMETERS
// - N_MMAP       2                        number of MMAP base/mask region pairs (1..8)
// - DEF_BOOT_PC  64'h180                  reset value of BOOT_PC
// - DEF_VM_MODE  2'd0                     reset VM mode (0 BARE, 1 SV39, 2 SV48)
// - DEF_MMAP_MASK 64'hffffffffe0000000    reset mask of region 0; regions 1..N-1 reset mask 0 (disabled)
// - DEF_FWD_EN   1'b1                     reset store-to-load forwarding enable
// - DEF_HPM_EN   1'b1                     reset HPM counter enable
// PORTS
// - clk_i          in   1      clock
// - rst_ni         in   1      synchronous reset, active low
// - req_valid_i    in   1      register request valid
// - req_ready_o    out  1      request accepted when valid & ready
// - req_we_i       in   1      1 = write, 0 = read
// - req_addr_i     in   5      64-bit word index
// - req_wdata_i    in   64     write data
// - rsp_valid_o    out  1      response valid, exactly 1 cycle after accept
// - rsp_rdata_o    out  64     read data from the shadow copy (0 on writes/errors)
// - rsp_err_o      out  1      unmapped address, or write while locked
// - drain_req_o    out  1      asks the core to drain; high in PENDING
// - quiesce_i      in   1      pipeline empty, no outstanding memory ops
// - cfg_update_o   out  1      1-cycle pulse in APPLY
// - vm_mode_o      out  2      active VM mode
// - boot_pc_o      out  64     active boot PC
// - fwd_en_o       out  1      active store-to-load forwarding enable
// - hpm_en_o       out  1      active HPM counter enable
// - chk_addr_i     in   64     address to classify (combinational)
// - chk_is_mmap_o  out  1      OR over k of ((chk_addr_i & MASK[k]) == (BASE[k] & MASK[k])) & (MASK[k]!=0)
// BEHAVIOUR
// - Map (word index):
//   - 0 CTRL: [0] fwd_en, [1] hpm_en, [3:2] vm_mode, [63] LOCK
//   - 1 BOOT_PC
//   - 2+2k MMAP_BASE[k]; 3+2k MMAP_MASK[k], k < N_MMAP
//   - Any other index: rsp_err_o=1, rdata 0, no state change.
// - WARL rules:
//   - vm_mode write of 2'b11 keeps the old value.
//   - BOOT_PC[1:0] is forced to 0.
//   - CTRL[62:4] reads 0.
//   - LOCK is sticky: a write of 0 to LOCK is ignored once LOCK is set in the shadow.
// - Reset (rst_ni=0 at a clk edge): shadow = active = defaults, LOCK=0, FSM=IDLE.
//   Outputs: rsp_valid_o=0, drain_req_o=0, cfg_update_o=0, req_ready_o=1, data outputs = defaults.
// - FSM:
//   - IDLE: an accepted, non-error write goes to PENDING. This holds even if the value is unchanged.
//   - PENDING: drain_req_o=1. Further writes are accepted and update the shadow. quiesce_i=1 goes to APPLY.
//   - APPLY (1 cycle): active <= shadow, cfg_update_o=1, req_ready_o=0, then IDLE.
// - req_ready_o=0 only in APPLY; otherwise 1.
// - A write accepted in the same cycle as quiesce_i in PENDING is included in the following APPLY.
// - Reads are allowed in every state except APPLY. Read data reflects the shadow, including writes not yet applied.
// - Write while active LOCK=1: rsp_err_o=1, shadow unchanged, FSM unchanged. Reads still work.
// - Writing LOCK=1 takes effect only after APPLY. Until then, further writes succeed.
// - Reset asserted in PENDING or APPLY discards the pending shadow and returns to defaults, with no cfg_update_o pulse.
// - Outputs are registered from the active copy. chk_is_mmap_o is combinational from chk_addr_i and the active copy.
// TESTING
// - Reset:
//   - Stimulus: hold rst_ni=0 for 2 cycles, then read CTRL and BOOT_PC.
//   - Required: CTRL reads 0x3 (fwd_en=1, hpm_en=1, BARE). BOOT_PC reads 0x180. chk_addr_i=0x2000_0000 gives chk_is_mmap_o=1; 0x1000 gives 0.
// - Deferred apply:
//   - Stimulus: write BOOT_PC=0x1003 with quiesce_i=0 for 5 cycles.
//   - Required: drain_req_o=1, boot_pc_o stays 0x180, a BOOT_PC read returns 0x1000.
//   - Stimulus: raise quiesce_i.
//   - Required: next cycle cfg_update_o=1 and req_ready_o=0; the cycle after, boot_pc_o=0x1000 and drain_req_o=0.
// - WARL and errors:
//   - Stimulus: write CTRL=0xC.
//   - Required: vm_mode stays 0.
//   - Stimulus: access index 2+2*N_MMAP.
//   - Required: rsp_err_o=1 one cycle after accept, rdata 0.
// - Lock:
//   - Stimulus: write CTRL[63]=1 and let it apply; then write BOOT_PC=0x2000.
//   - Required: rsp_err_o=1, shadow and active unchanged, FSM stays IDLE. A CTRL read returns bit63=1.
// - Simultaneous write and quiesce:
//   - Stimulus: in PENDING, write MMAP_MASK[1]=0xffff_0000 in the same cycle quiesce_i=1.
//   - Required: APPLY copies the new mask; chk_addr_i=BASE[1]|0x10 gives chk_is_mmap_o=1.
// - Reset mid-operation:
//   - Stimulus: assert rst_ni=0 while in PENDING.
//   - Required: no cfg_update_o pulse; all outputs return to defaults; req_ready_o=1.

Source files
------------

// File: rtl/len5_runtime_cfg.sv
// Runtime core configuration: register port writes a shadow copy, and a drain
// handshake promotes the shadow to the active copy once the pipeline is quiescent.
module len5_runtime_cfg #(
  parameter int unsigned N_MMAP        = 2,
  parameter logic [63:0] DEF_BOOT_PC   = 64'h180,
  parameter logic [1:0]  DEF_VM_MODE   = 2'd0,
  parameter logic [63:0] DEF_MMAP_BASE = 64'h2000_0000,
  parameter logic [63:0] DEF_MMAP_MASK = 64'hffff_ffff_e000_0000,
  parameter logic        DEF_FWD_EN    = 1'b1,
  parameter logic        DEF_HPM_EN    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [4:0]  req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        drain_req_o,
  input  logic        quiesce_i,
  output logic        cfg_update_o,
  output logic [1:0]  vm_mode_o,
  output logic [63:0] boot_pc_o,
  output logic        fwd_en_o,
  output logic        hpm_en_o,
  input  logic [63:0] chk_addr_i,
  output logic        chk_is_mmap_o
);

  localparam int unsigned N_REG = 2 + 2 * N_MMAP;

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;
  state_t state_q, state_d;

  logic        sh_fwd, sh_hpm, sh_lock;
  logic [1:0]  sh_vm;
  logic [63:0] sh_pc;
  logic [63:0] sh_base [N_MMAP];
  logic [63:0] sh_mask [N_MMAP];

  logic        act_fwd, act_hpm, act_lock;
  logic [1:0]  act_vm;
  logic [63:0] act_pc;
  logic [63:0] act_base [N_MMAP];
  logic [63:0] act_mask [N_MMAP];

  logic        in_apply, accept, addr_ok, req_err, wr_en;
  logic [63:0] rd_data;

  // Acceptance depends only on the registered state, keeping ready free of loops.
  assign in_apply     = (state_q == APPLY);
  assign req_ready_o  = ~in_apply;
  assign drain_req_o  = (state_q == PENDING);
  assign cfg_update_o = in_apply;
  assign accept       = req_valid_i & ~in_apply;
  assign addr_ok      = 32'(req_addr_i) < N_REG;
  assign req_err      = ~addr_ok | (req_we_i & act_lock);
  assign wr_en        = accept & req_we_i & ~req_err;

  always_comb begin
    rd_data = '0;
    if (req_addr_i == 5'd0) rd_data = {sh_lock, 59'd0, sh_vm, sh_hpm, sh_fwd};
    if (req_addr_i == 5'd1) rd_data = sh_pc;
    for (int unsigned k = 0; k < N_MMAP; k++) begin
      if (req_addr_i == 5'(2 + 2 * k)) rd_data = sh_base[k];
      if (req_addr_i == 5'(3 + 2 * k)) rd_data = sh_mask[k];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_en) state_d = PENDING;
      PENDING: if (quiesce_i) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_fwd  <= DEF_FWD_EN;
      sh_hpm  <= DEF_HPM_EN;
      sh_vm   <= DEF_VM_MODE;
      sh_lock <= 1'b0;
      sh_pc   <= DEF_BOOT_PC;
      for (int unsigned k = 0; k < N_MMAP; k++) begin
        sh_base[k] <= (k == 0) ? DEF_MMAP_BASE : '0;
        sh_mask[k] <= (k == 0) ? DEF_MMAP_MASK : '0;
      end
    end else if (wr_en) begin
      if (req_addr_i == 5'd0) begin
        sh_fwd  <= req_wdata_i[0];
        sh_hpm  <= req_wdata_i[1];
        if (req_wdata_i[3:2] != 2'b11) sh_vm <= req_wdata_i[3:2];
        sh_lock <= sh_lock | req_wdata_i[63];
      end
      if (req_addr_i == 5'd1) sh_pc <= {req_wdata_i[63:2], 2'b00};
      for (int unsigned k = 0; k < N_MMAP; k++) begin
        if (req_addr_i == 5'(2 + 2 * k)) sh_base[k] <= req_wdata_i;
        if (req_addr_i == 5'(3 + 2 * k)) sh_mask[k] <= req_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      act_fwd  <= DEF_FWD_EN;
      act_hpm  <= DEF_HPM_EN;
      act_vm   <= DEF_VM_MODE;
      act_lock <= 1'b0;
      act_pc   <= DEF_BOOT_PC;
      for (int unsigned k = 0; k < N_MMAP; k++) begin
        act_base[k] <= (k == 0) ? DEF_MMAP_BASE : '0;
        act_mask[k] <= (k == 0) ? DEF_MMAP_MASK : '0;
      end
    end else if (in_apply) begin
      act_fwd  <= sh_fwd;
      act_hpm  <= sh_hpm;
      act_vm   <= sh_vm;
      act_lock <= sh_lock;
      act_pc   <= sh_pc;
      for (int unsigned k = 0; k < N_MMAP; k++) begin
        act_base[k] <= sh_base[k];
        act_mask[k] <= sh_mask[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= accept;
      rsp_err_o   <= accept & req_err;
      rsp_rdata_o <= (accept & ~req_we_i & ~req_err) ? rd_data : '0;
    end
  end

  assign vm_mode_o = act_vm;
  assign boot_pc_o = act_pc;
  assign fwd_en_o  = act_fwd;
  assign hpm_en_o  = act_hpm;

  always_comb begin
    chk_is_mmap_o = 1'b0;
    for (int unsigned k = 0; k < N_MMAP; k++) begin
      if ((act_mask[k] != '0) &&
          ((chk_addr_i & act_mask[k]) == (act_base[k] & act_mask[k])))
        chk_is_mmap_o = 1'b1;
    end
  end

endmodule
